// File: rtl/picoramsoc_iomem_timer.sv
// Memory-mapped down-counting timer on the iomem bus.
// One-shot/periodic modes, prescaler, W1C expiry flag driving irq.
module picoramsoc_iomem_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  logic        en;
  logic        periodic;
  logic        irq_en;
  logic        expired;
  logic [15:0] presc;
  logic [15:0] pcnt;
  logic [31:0] load;
  logic [31:0] count;

  logic        sel;
  logic        hit;
  logic        wr;
  logic [1:0]  idx;
  logic        wr_ctrl;
  logic        wr_load;
  logic        w1c;
  logic [31:0] ctrl_q;
  logic [31:0] ctrl_w;
  logic [31:0] load_d;
  logic        tick;
  logic        expire;
  logic        start;
  logic [31:0] rd_val;
  logic        unused;

  assign sel     = iomem_valid &&
                   iomem_addr[31:4] == BASE_ADDR[31:4];
  assign hit     = sel && !iomem_ready;
  assign wr      = hit && |iomem_wstrb;
  assign idx     = iomem_addr[3:2];
  assign wr_ctrl = wr && idx == 2'd0;
  assign wr_load = wr && idx == 2'd1;
  assign w1c     = wr && idx == 2'd3 &&
                   iomem_wstrb[0] && iomem_wdata[0];

  assign ctrl_q = {presc, 13'b0, irq_en, periodic, en};
  assign ctrl_w = merge(ctrl_q, iomem_wdata, iomem_wstrb);
  assign load_d = wr_load ?
                  merge(load, iomem_wdata, iomem_wstrb) : load;

  assign tick   = en && pcnt == presc;
  assign expire = tick && count == 32'd0;
  assign start  = wr_ctrl && !en && ctrl_w[0];

  assign unused = ^{iomem_addr[1:0], ctrl_w[15:3]};

  always_comb begin
    rd_val = 32'd0;
    unique case (idx)
      2'd0: rd_val = ctrl_q;
      2'd1: rd_val = load;
      2'd2: rd_val = count;
      2'd3: rd_val = {31'd0, expired};
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'd0;
    end else begin
      iomem_ready <= sel && !iomem_ready;
      iomem_rdata <= (hit && !wr) ? rd_val : 32'd0;
    end
  end

  // Bus write to EN beats the one-shot auto-clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en       <= 1'b0;
      periodic <= 1'b0;
      irq_en   <= 1'b0;
      presc    <= 16'd0;
      load     <= 32'd0;
    end else begin
      load <= load_d;
      if (wr_ctrl) begin
        en       <= ctrl_w[0];
        periodic <= ctrl_w[1];
        irq_en   <= ctrl_w[2];
        presc    <= ctrl_w[31:16];
      end else if (expire && !periodic) begin
        en <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= 32'd0;
      pcnt  <= 16'd0;
    end else if (start) begin
      count <= load_d;
      pcnt  <= 16'd0;
    end else if (tick) begin
      pcnt <= 16'd0;
      if (count != 32'd0)
        count <= count - 32'd1;
      else if (periodic)
        count <= load;
    end else if (en) begin
      pcnt <= pcnt + 16'd1;
    end
  end

  // Expiry set wins over a same-edge clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      expired <= 1'b0;
    else if (expire)
      expired <= 1'b1;
    else if (w1c)
      expired <= 1'b0;
  end

  assign irq = expired && irq_en;

endmodule
